// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore-style sequencing controller for the multicycle RV32I datapath. Each
//   instruction is stepped through fetch, decode, execute, memory and
//   writeback. The controller drives every datapath enable and mux select,
//   and also produces the ALU opcode.
//
// Parameters
//   MEM_WAIT : 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready, 0 = ignore mem_ready
//   EN_EXT   : 1 = decode bne, xor/xori, srl/srli; 0 = treat them as illegal
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   Opcode, funct3, funct7b5    instruction fields from the instruction register
//   Zero                        ALU zero flag (branch resolution)
//   mem_ready                   memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite          datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl       datapath mux selects / ALU op
//   Illegal                     one-cycle pulse in DECODE for an undecodable instruction
//   InstrDone                   one-cycle pulse in the final state of each instruction
//   State                       current state, for debug
module multicycle_control_unit #(
  parameter int MEM_WAIT = 0,
  parameter int EN_EXT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic       InstrDone,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       ext;
  logic       mem_go;
  logic       is_bne;
  logic [2:0] alu_fn;
  logic       fn_ok;
  logic       legal;

  logic       pc_update;
  logic       branch;
  logic       adr_src;
  logic       mem_wr;
  logic       ir_wr;
  logic       reg_wr;
  logic       done;
  logic       illegal;
  logic [1:0] res_src;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [2:0] alu_ctl;

  assign ext    = (EN_EXT != 0);
  // Without the handshake every memory-facing state completes in one cycle.
  assign mem_go = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign is_bne = (funct3 == 3'b001);

  // ALU function for R/I-type; fn_ok is low for encodings this core does not execute.
  always_comb begin
    alu_fn = ALU_ADD;
    fn_ok  = 1'b1;
    case (funct3)
      3'b000: alu_fn = ((Opcode == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_fn = ALU_SLL;
      3'b010: alu_fn = ALU_SLT;
      3'b110: alu_fn = ALU_OR;
      3'b111: alu_fn = ALU_AND;
      3'b100: begin
        alu_fn = ALU_XOR;
        fn_ok  = ext;
      end
      3'b101: begin
        alu_fn = ALU_SRL;
        fn_ok  = ext & ~funct7b5;
      end
      default: fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (Opcode)
      OP_LW, OP_SW, OP_JAL: legal = 1'b1;
      OP_R, OP_I:           legal = fn_ok;
      OP_BR:                legal = (funct3 == 3'b000) | (is_bne & ext);
      default:              legal = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (legal) begin
          case (Opcode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_R:         next_state = S_EXECR;
            OP_I:         next_state = S_EXECI;
            OP_JAL:       next_state = S_JAL;
            OP_BR:        next_state = S_BRANCH;
            default:      next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   next_state = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_go ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: next_state = mem_go ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
      // MEMWB, ALUWB, BRANCH and the unused codes all return to FETCH.
      default:    next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    adr_src   = 1'b0;
    mem_wr    = 1'b0;
    ir_wr     = 1'b0;
    reg_wr    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    res_src   = 2'b00;
    src_a     = 2'b00;
    src_b     = 2'b00;
    alu_ctl   = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_wr     = mem_go;
        pc_update = mem_go;
        src_b     = 2'b10;
        res_src   = 2'b10;
      end
      S_DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        illegal = ~legal;
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        res_src = 2'b01;
        reg_wr  = 1'b1;
        done    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_wr  = mem_go;
        done    = mem_go;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_ctl = alu_fn;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_ctl = alu_fn;
      end
      S_ALUWB: begin
        reg_wr = 1'b1;
        done   = 1'b1;
      end
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        src_a   = 2'b10;
        alu_ctl = ALU_SUB;
        branch  = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (Opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // bne inverts the sense of Zero; reset masks every write and pulse output.
  assign PCWrite    = ~reset & (pc_update | (branch & (Zero ^ is_bne)));
  assign IRWrite    = ~reset & ir_wr;
  assign RegWrite   = ~reset & reg_wr;
  assign MemWrite   = ~reset & mem_wr;
  assign Illegal    = ~reset & illegal;
  assign InstrDone  = ~reset & done;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = res_src;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign ALUControl = alu_ctl;
  assign State      = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//   Directed bench for multicycle_control_unit. Instance u0 (MEM_WAIT=1,
//   EN_EXT=1) is compared every cycle against a per-instruction step-list
//   model. Instance u1 (MEM_WAIT=0, EN_EXT=0) is checked with literal
//   expectations.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, funct7b5, Zero, mem_ready;
  logic [6:0] Opcode;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, InstrDone;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic       reset_b, funct7b5_b, Zero_b, mem_ready_b;
  logic [6:0] Opcode_b;
  logic [2:0] funct3_b;
  logic       PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, Illegal_b, InstrDone_b;
  logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b;
  logic [2:0] ALUControl_b;
  logic [3:0] State_b;

  multicycle_control_unit #(.MEM_WAIT(1), .EN_EXT(1)) u0 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .Illegal(Illegal), .InstrDone(InstrDone), .State(State)
  );

  multicycle_control_unit #(.MEM_WAIT(0), .EN_EXT(0)) u1 (
    .clk(clk), .reset(reset_b), .Opcode(Opcode_b), .funct3(funct3_b), .funct7b5(funct7b5_b),
    .Zero(Zero_b), .mem_ready(mem_ready_b), .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b),
    .MemWrite(MemWrite_b), .IRWrite(IRWrite_b), .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b),
    .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b), .RegWrite(RegWrite_b), .ALUControl(ALUControl_b),
    .Illegal(Illegal_b), .InstrDone(InstrDone_b), .State(State_b)
  );

  // One expected cycle; -1 in a select field means don't-care.
  typedef struct {
    int st; int pcw; int irw; int regw; int memw; int ill; int done;
    int adr; int rs; int sa; int sb; int alu; int rdy;
  } step_t;

  step_t plan[$];
  step_t e;
  bit    chk_en = 1'b0;
  int    total = 0, bad = 0;
  int    cyc_seen, irw_seen, regw_seen, memw_seen, ill_seen, pcw_seen, done_seen;
  int    last_alu;

  // ALU code by funct3: add sll slt -- xor srl or and
  int alu_tab[8] = '{0, 4, 5, -1, 6, 7, 3, 2};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input int st, input int rdy);
    step_t s;
    s.st = st; s.pcw = 0; s.irw = 0; s.regw = 0; s.memw = 0; s.ill = 0; s.done = 0;
    s.adr = -1; s.rs = -1; s.sa = -1; s.sb = -1; s.alu = -1; s.rdy = rdy;
    return s;
  endfunction

  function automatic int imm_of(input logic [6:0] op);
    if (op == OP_LW || op == OP_I) return 0;
    if (op == OP_SW)  return 1;
    if (op == OP_BR)  return 2;
    if (op == OP_JAL) return 3;
    return -1;
  endfunction

  // Expand one instruction into its expected cycle list.
  // fw/mw = cycles mem_ready is held low in FETCH / in the memory state.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input int fw, input int mw);
    step_t s;
    int    cls, alu;
    bit    bad_ins;
    plan.delete();
    cls = (op == OP_LW) ? 0 : (op == OP_SW) ? 1 : (op == OP_R) ? 2 :
          (op == OP_I) ? 3 : (op == OP_JAL) ? 4 : (op == OP_BR) ? 5 : 6;
    alu = -1;
    if (cls == 2 || cls == 3) begin
      alu = alu_tab[f3];
      if (f3 == 3'd5 && f7) alu = -1;
      if (cls == 2 && f3 == 3'd0 && f7) alu = 1;
    end
    bad_ins = (cls == 6) || ((cls == 2 || cls == 3) && alu < 0) || (cls == 5 && f3 > 3'd1);
    for (int i = 0; i <= fw; i++) begin
      s = mk(0, (i == fw) ? 1 : 0);
      s.adr = 0; s.sa = 0; s.sb = 2; s.rs = 2; s.alu = 0;
      s.irw = (i == fw) ? 1 : 0; s.pcw = s.irw;
      plan.push_back(s);
    end
    s = mk(1, 0); s.sa = 1; s.sb = 1; s.alu = 0; s.ill = bad_ins ? 1 : 0;
    plan.push_back(s);
    if (bad_ins) return;
    case (cls)
      0, 1: begin
        s = mk(2, 0); s.sa = 2; s.sb = 1; s.alu = 0; plan.push_back(s);
        for (int i = 0; i <= mw; i++) begin
          s = mk((cls == 0) ? 3 : 5, (i == mw) ? 1 : 0); s.adr = 1;
          if (cls == 0) s.rs = 0;
          else begin s.memw = (i == mw) ? 1 : 0; s.done = s.memw; end
          plan.push_back(s);
        end
        if (cls == 0) begin
          s = mk(4, 0); s.rs = 1; s.regw = 1; s.done = 1; plan.push_back(s);
        end
      end
      2, 3: begin
        s = mk((cls == 2) ? 6 : 8, 0); s.sa = 2; s.sb = (cls == 2) ? 0 : 1; s.alu = alu;
        plan.push_back(s);
        s = mk(7, 0); s.rs = 0; s.regw = 1; s.done = 1; plan.push_back(s);
      end
      4: begin
        s = mk(9, 0); s.sa = 1; s.sb = 2; s.alu = 0; s.rs = 0; s.pcw = 1; plan.push_back(s);
        s = mk(7, 0); s.rs = 0; s.regw = 1; s.done = 1; plan.push_back(s);
      end
      default: begin
        s = mk(10, 0); s.sa = 2; s.sb = 0; s.alu = 1; s.rs = 0; s.done = 1;
        s.pcw = (f3 == 3'd0) ? int'(z) : int'(!z);
        plan.push_back(s);
      end
    endcase
  endtask

  // Starts at posedge+1 with u0 in FETCH; ends at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw);
    build(op, f3, f7, z, fw, mw);
    Opcode = op; funct3 = f3; funct7b5 = f7; Zero = z;
    cyc_seen = 0; irw_seen = 0; regw_seen = 0; memw_seen = 0;
    ill_seen = 0; pcw_seen = 0; done_seen = 0; last_alu = -1;
    foreach (plan[i]) begin
      e = plan[i];
      mem_ready = e.rdy[0];
      chk_en = 1'b1;
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cyc_seen++;
      irw_seen  += int'(IRWrite);
      regw_seen += int'(RegWrite);
      memw_seen += int'(MemWrite);
      ill_seen  += int'(Illegal);
      pcw_seen  += int'(PCWrite);
      done_seen += int'(InstrDone);
      if (e.st == 6 || e.st == 8) last_alu = int'(ALUControl);
      chk("State", int'(State), e.st);
      chk("PCWrite", int'(PCWrite), e.pcw);
      chk("IRWrite", int'(IRWrite), e.irw);
      chk("RegWrite", int'(RegWrite), e.regw);
      chk("MemWrite", int'(MemWrite), e.memw);
      chk("Illegal", int'(Illegal), e.ill);
      chk("InstrDone", int'(InstrDone), e.done);
      if (e.adr >= 0) chk("AdrSrc", int'(AdrSrc), e.adr);
      if (e.rs >= 0)  chk("ResultSrc", int'(ResultSrc), e.rs);
      if (e.sa >= 0)  chk("ALUSrcA", int'(ALUSrcA), e.sa);
      if (e.sb >= 0)  chk("ALUSrcB", int'(ALUSrcB), e.sb);
      if (e.alu >= 0) chk("ALUControl", int'(ALUControl), e.alu);
      if (imm_of(Opcode) >= 0) chk("ImmSrc", int'(ImmSrc), imm_of(Opcode));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    reset_b = 1'b1; Opcode_b = 7'd0; funct3_b = 3'd0; funct7b5_b = 1'b0; Zero_b = 1'b0;
    mem_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(State), 0);
    chk("reset_enables", int'({PCWrite, IRWrite, RegWrite, MemWrite, Illegal, InstrDone}), 0);
    reset = 1'b0;

    // Model pins: hand-derived cycle counts and pulse counts.
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("add_cycles", cyc_seen, 4);
    chk("add_alu", last_alu, 0);
    run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
    chk("sub_alu", last_alu, 1);
    chk("sub_regwrite_count", regw_seen, 1);
    chk("sub_done_count", done_seen, 1);
    run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 2, 2);
    chk("lw_wait_cycles", cyc_seen, 9);
    chk("lw_wait_irwrite_count", irw_seen, 1);
    chk("lw_wait_regwrite_count", regw_seen, 1);
    run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    chk("lw_cycles", cyc_seen, 5);
    run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 1, 1);
    chk("sw_wait_cycles", cyc_seen, 6);
    chk("sw_memwrite_count", memw_seen, 1);
    run_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    chk("beq_taken_pcwrite_count", pcw_seen, 2);
    chk("beq_cycles", cyc_seen, 3);
    run_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("beq_not_taken_pcwrite_count", pcw_seen, 1);
    run_instr(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0);
    chk("bne_zero_pcwrite_count", pcw_seen, 1);
    run_instr(OP_BR, 3'b001, 1'b0, 1'b0, 0, 0);
    chk("bne_nonzero_pcwrite_count", pcw_seen, 2);
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("jal_cycles", cyc_seen, 4);
    chk("jal_pcwrite_count", pcw_seen, 2);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("illegal_cycles", cyc_seen, 2);
    chk("illegal_pulse_count", ill_seen, 1);
    chk("illegal_writes", regw_seen + memw_seen, 0);

    // Remaining funct decodes, legal and illegal.
    run_instr(OP_I, 3'b100, 1'b0, 1'b0, 0, 0);
    chk("xori_alu", last_alu, 6);
    run_instr(OP_I, 3'b101, 1'b0, 1'b0, 0, 0);
    run_instr(OP_I, 3'b101, 1'b1, 1'b0, 0, 0);
    chk("srai_illegal", ill_seen, 1);
    run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(OP_I, 3'b001, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'b110, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'b100, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'b101, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'b011, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BR, 3'b100, 1'b0, 1'b1, 0, 0);
    run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 0);

    // Reset while an lw waits in MEMREAD.
    Opcode = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("memread_wait_state", int'(State), 3);
    chk("memread_wait_adrsrc", int'(AdrSrc), 1);
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("reset_mid_enables", int'({PCWrite, IRWrite, RegWrite, MemWrite, Illegal, InstrDone}), 0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_held_state", int'(State), 0);
      chk("reset_held_enables", int'({PCWrite, IRWrite, RegWrite, MemWrite, Illegal, InstrDone}), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_state", int'(State), 0);
    chk("post_reset_irwrite", int'(IRWrite), 1);
    chk("post_reset_pcwrite", int'(PCWrite), 1);
    @(negedge clk);
    chk("post_reset_decode", int'(State), 1);
    @(posedge clk); #1;
    reset = 1'b1;

    // u1: MEM_WAIT=0 ignores mem_ready (held low); EN_EXT=0 rejects bne/xor/srl.
    reset_b = 1'b0; Opcode_b = OP_BR; funct3_b = 3'b001; Zero_b = 1'b1;
    @(negedge clk);
    chk("b_fetch_state", int'(State_b), 0);
    chk("b_fetch_irwrite", int'(IRWrite_b), 1);
    chk("b_fetch_selects", int'({AdrSrc_b, ALUSrcA_b, ALUSrcB_b, ResultSrc_b}), 5'b0_00_10_10);
    @(negedge clk);
    chk("b_bne_state", int'(State_b), 1);
    chk("b_bne_illegal", int'(Illegal_b), 1);
    @(negedge clk);
    chk("b_bne_refetch", int'(State_b), 0);
    @(posedge clk); #1;
    Opcode_b = OP_R; funct3_b = 3'b100;
    @(negedge clk);
    chk("b_xor_illegal", int'(Illegal_b), 1);
    @(posedge clk); #1;
    Opcode_b = OP_R; funct3_b = 3'b101; funct7b5_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_srl_illegal", int'(Illegal_b), 1);
    @(posedge clk); #1;
    Opcode_b = OP_BR; funct3_b = 3'b000; Zero_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b_beq_decode_legal", int'(Illegal_b), 0);
    chk("b_beq_immsrc", int'(ImmSrc_b), 2);
    @(negedge clk);
    chk("b_beq_state", int'(State_b), 10);
    chk("b_beq_pcwrite", int'(PCWrite_b), 1);
    chk("b_beq_alu", int'(ALUControl_b), 1);
    chk("b_beq_regwrite", int'(RegWrite_b), 0);
    @(posedge clk); #1;
    Opcode_b = OP_SW; funct3_b = 3'b010;
    repeat (4) @(negedge clk);
    chk("b_sw_state", int'(State_b), 5);
    chk("b_sw_memwrite", int'(MemWrite_b), 1);
    chk("b_sw_done", int'(InstrDone_b), 1);
    @(negedge clk);
    chk("b_sw_refetch", int'(State_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
